// File: rtl/spi_byte_receiver_pkg.sv
// Shared encodings and helpers for the SPI byte receiver.
package spi_byte_receiver_pkg;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RECV = 1'b1;

   localparam int BYTE_BITS  = 8;
   localparam int CNT_W      = $clog2(BYTE_BITS);
   localparam int FIFO_DEPTH = 4;
   localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic                 first;
      logic [BYTE_BITS-1:0] data;
   } rx_entry_t;

   function automatic logic [BYTE_BITS-1:0] shift_in(input logic [BYTE_BITS-1:0] sr,
                                                     input logic                 b,
                                                     input logic                 msb_first);
      if (msb_first) return {sr[BYTE_BITS-2:0], b};
      else           return {b, sr[BYTE_BITS-1:1]};
   endfunction

endpackage

// File: rtl/spi_byte_receiver_bit_sync.sv
// Multi-flop synchroniser for one asynchronous bit; resets to 0.
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) chain <= '0;
      else     chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_byte_receiver.sv
// CLK-domain SPI byte receiver with idle-timeout framing.
// Optional 4-entry output FIFO with READY/OVERRUN enabled by macro SPI_RX_FIFO_EN.
module spi_byte_receiver
   import spi_byte_receiver_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int IDLE_CYCLES = 64,
   parameter int MSB_FIRST   = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       SCLK,
   input  logic       MOSI,
   input  logic       READY,
   output logic [7:0] DATA,
   output logic       VALID,
   output logic       FIRST,
   output logic       ACTIVE,
   output logic       OVERRUN
);

   localparam int               TMR_W   = $clog2(IDLE_CYCLES);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(IDLE_CYCLES - 1);

   logic                 sync_sclk, sync_mosi, sclk_prev;
   logic                 rise, sclk_edge, byte_done;
   logic                 state, first_mark;
   logic [CNT_W-1:0]     bit_cnt;
   logic [TMR_W-1:0]     timer;
   logic [BYTE_BITS-1:0] shreg, sh_nxt;
   logic [BYTE_BITS-1:0] byte_p0, byte_p1, data_p2;
   logic                 first_p0, first_p1, first_p2;
   logic                 vld_p0, vld_p1, vld_p2;

   bit_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (.clk(CLK), .rst(RST), .d(SCLK), .q(sync_sclk));
   bit_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clk(CLK), .rst(RST), .d(MOSI), .q(sync_mosi));

   assign rise      = sync_sclk & ~sclk_prev;
   assign sclk_edge = sync_sclk ^ sclk_prev;
   assign sh_nxt    = shift_in(shreg, sync_mosi, MSB_FIRST != 0);
   assign byte_done = (state == ST_RECV) && rise && (bit_cnt == CNT_W'(BYTE_BITS - 1));
   assign ACTIVE    = (state == ST_RECV);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sclk_prev  <= 1'b0;
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         timer      <= '0;
         first_mark <= 1'b0;
         vld_p0     <= 1'b0;
         vld_p1     <= 1'b0;
         vld_p2     <= 1'b0;
         data_p2    <= '0;
         first_p2   <= 1'b0;
      end else begin
         sclk_prev <= sync_sclk;
         vld_p0    <= byte_done;
         vld_p1    <= vld_p0;
         vld_p2    <= vld_p1;
         if (vld_p1) begin
            data_p2  <= byte_p1;
            first_p2 <= first_p1;
         end
         if (sclk_edge)              timer <= '0;
         else if (timer != TMR_MAX)  timer <= timer + TMR_W'(1);
         if (state == ST_IDLE) begin
            if (rise) begin
               state      <= ST_RECV;
               bit_cnt    <= CNT_W'(1);
               first_mark <= 1'b1;
            end
         end else begin
            if (rise) begin
               if (byte_done) begin
                  bit_cnt    <= '0;
                  first_mark <= 1'b0;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end else if (!sclk_edge && timer == TMR_MAX) begin
               // timeout drops any partial byte; the next frame restarts at bit 0
               state   <= ST_IDLE;
               bit_cnt <= '0;
            end
         end
      end
   end

   // p0: byte assembled, p1: delay stage, p2: output register
   always_ff @(posedge CLK) begin
      if (rise) shreg <= sh_nxt;
      if (byte_done) begin
         byte_p0  <= sh_nxt;
         first_p0 <= first_mark;
      end
      byte_p1  <= byte_p0;
      first_p1 <= first_p0;
   end

`ifdef SPI_RX_FIFO_EN
   rx_entry_t             mem [FIFO_DEPTH];
   logic [FIFO_PTR_W-1:0] wr_ptr, rd_ptr;
   logic [FIFO_PTR_W:0]   count;
   logic                  overrun, empty, full, pop, push_ok;

   assign empty   = (count == '0);
   assign full    = (count == (FIFO_PTR_W+1)'(FIFO_DEPTH));
   assign pop     = !empty && READY;
   assign push_ok = vld_p2 && (!full || pop);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (pop)     rd_ptr <= rd_ptr + FIFO_PTR_W'(1);
         if (push_ok) wr_ptr <= wr_ptr + FIFO_PTR_W'(1);
         if (vld_p2 && !push_ok) overrun <= 1'b1;
         if (push_ok && !pop)      count <= count + (FIFO_PTR_W+1)'(1);
         else if (!push_ok && pop) count <= count - (FIFO_PTR_W+1)'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (push_ok) mem[wr_ptr] <= '{first: first_p2, data: data_p2};
   end

   assign VALID   = !empty;
   assign DATA    = empty ? 8'h00 : mem[rd_ptr].data;
   assign FIRST   = !empty && mem[rd_ptr].first;
   assign OVERRUN = overrun;
`else
   logic ready_unused;
   assign ready_unused = READY;

   assign VALID   = vld_p2;
   assign DATA    = data_p2;
   assign FIRST   = vld_p2 & first_p2;
   assign OVERRUN = 1'b0;
`endif

endmodule
